// File: rtl/seq_multiplier_param.sv
// Sequential shift-and-add multiplier, N x N -> 2N, unsigned or two's-complement.
// Multiplies operand magnitudes, stops early once the remaining multiplier bits are zero.
//
// state | meaning
// IDLE  | waiting for Start; operands captured on the accepting edge
// CALC  | one multiplier bit consumed per edge until Breg is zero
// DONE  | product in P, Done held until Start drops
module seq_multiplier_param #(
    parameter int N = 8
) (
    input  logic           Clock,
    input  logic           Reset,
    input  logic           Start,
    input  logic           Signed,
    input  logic [N-1:0]   DataA,
    input  logic [N-1:0]   DataB,
    output logic [2*N-1:0] P,
    output logic           Done,
    output logic           Busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [N-1:0]   ZERO_N  = '0;
    localparam logic [2*N-1:0] ZERO_2N = '0;

    state_t         state;
    state_t         state_nxt;
    logic [2*N-1:0] a_reg;
    logic [2*N-1:0] acc;
    logic [N-1:0]   b_reg;
    logic           neg;
    logic [N-1:0]   mag_a;
    logic [N-1:0]   mag_b;

    // Magnitude of -2^(N-1) wraps to 2^(N-1), which still fits as unsigned N bits.
    always_comb begin
        mag_a = DataA;
        mag_b = DataB;
        if (Signed && DataA[N-1]) mag_a = ZERO_N - DataA;
        if (Signed && DataB[N-1]) mag_b = ZERO_N - DataB;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (Start) state_nxt = CALC;
            CALC:    if (b_reg == ZERO_N) state_nxt = DONE;
            DONE:    if (!Start) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign Busy = (state == CALC);
    assign Done = (state == DONE);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            neg   <= 1'b0;
            P     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        a_reg <= {ZERO_N, mag_a};
                        b_reg <= mag_b;
                        acc   <= '0;
                        neg   <= Signed & (DataA[N-1] ^ DataB[N-1]);
                    end
                end
                CALC: begin
                    if (b_reg == ZERO_N) begin
                        P <= neg ? (ZERO_2N - acc) : acc;
                    end else begin
                        if (b_reg[0]) acc <= acc + a_reg;
                        a_reg <= a_reg << 1;
                        b_reg <= b_reg >> 1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier_param.sv
// Directed bench for seq_multiplier_param (N=8): vector table plus reset and
// disturbance sequences; inputs driven on the falling edge, outputs sampled #1 after rising.
module tb_seq_multiplier_param;

    localparam int N = 8;

    logic           Clock;
    logic           Reset;
    logic           Start;
    logic           Signed;
    logic [N-1:0]   DataA;
    logic [N-1:0]   DataB;
    logic [2*N-1:0] P;
    logic           Done;
    logic           Busy;

    int n_checks = 0;
    int n_pass   = 0;

    seq_multiplier_param #(.N(N)) dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .Start  (Start),
        .Signed (Signed),
        .DataA  (DataA),
        .DataB  (DataB),
        .P      (P),
        .Done   (Done),
        .Busy   (Busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic           sgn;
        logic [2*N-1:0] p;
        int             lat;
        int             hold;
        bit             disturb;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic run_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic sgn, input logic [2*N-1:0] exp_p, input int exp_lat,
                          input int hold, input bit disturb);
        int cycles;
        bit busy_ok;
        logic [2*N-1:0] p_done;
        @(negedge Clock);
        Start  = 1'b1;
        Signed = sgn;
        DataA  = a;
        DataB  = b;
        @(posedge Clock);
        #1;
        check({name, "_busy_e0"}, {30'd0, Busy, Done}, 32'h2);
        cycles  = 0;
        busy_ok = 1'b1;
        while (!Done && cycles < N + 4) begin
            @(negedge Clock);
            if (disturb) begin
                DataA  = N'($urandom);
                DataB  = N'($urandom);
                Signed = ~Signed;
                Start  = ~Start;
            end
            @(posedge Clock);
            #1;
            cycles++;
            if (!Done && !Busy) busy_ok = 1'b0;
        end
        Start = 1'b1;
        check({name, "_latency"}, cycles, exp_lat);
        check({name, "_p"}, {16'd0, P}, {16'd0, exp_p});
        check({name, "_busy_calc"}, {31'd0, busy_ok}, 32'd1);
        check({name, "_busy_in_done"}, {31'd0, Busy}, 32'd0);
        p_done = P;
        for (int i = 0; i < hold; i++) begin
            @(posedge Clock);
            #1;
            check({name, "_hold_done"}, {31'd0, Done}, 32'd1);
            check({name, "_hold_p"}, {16'd0, P}, {16'd0, p_done});
        end
        @(negedge Clock);
        Start = 1'b0;
        @(posedge Clock);
        #1;
        check({name, "_done_drop"}, {30'd0, Busy, Done}, 32'd0);
        check({name, "_p_kept"}, {16'd0, P}, {16'd0, exp_p});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{a: 8'd13,  b: 8'd11,  sgn: 1'b0, p: 16'h008F, lat: 5, hold: 3, disturb: 1'b0};
        vecs[1]  = '{a: 8'd255, b: 8'd255, sgn: 1'b0, p: 16'hFE01, lat: 9, hold: 0, disturb: 1'b0};
        vecs[2]  = '{a: 8'd200, b: 8'd0,   sgn: 1'b0, p: 16'h0000, lat: 1, hold: 0, disturb: 1'b0};
        vecs[3]  = '{a: 8'h05,  b: 8'hFD,  sgn: 1'b1, p: 16'hFFF1, lat: 3, hold: 0, disturb: 1'b0};
        vecs[4]  = '{a: 8'hFF,  b: 8'hFF,  sgn: 1'b1, p: 16'h0001, lat: 2, hold: 1, disturb: 1'b0};
        vecs[5]  = '{a: 8'h80,  b: 8'h80,  sgn: 1'b1, p: 16'h4000, lat: 9, hold: 0, disturb: 1'b0};
        vecs[6]  = '{a: 8'h80,  b: 8'h7F,  sgn: 1'b1, p: 16'hC080, lat: 8, hold: 0, disturb: 1'b0};
        vecs[7]  = '{a: 8'h00,  b: 8'hFB,  sgn: 1'b1, p: 16'h0000, lat: 4, hold: 0, disturb: 1'b0};
        vecs[8]  = '{a: 8'd128, b: 8'd2,   sgn: 1'b0, p: 16'h0100, lat: 3, hold: 0, disturb: 1'b0};
        vecs[9]  = '{a: 8'd13,  b: 8'd11,  sgn: 1'b0, p: 16'h008F, lat: 5, hold: 1, disturb: 1'b1};
        vecs[10] = '{a: 8'hFD,  b: 8'h86,  sgn: 1'b1, p: 16'h016E, lat: 8, hold: 0, disturb: 1'b1};

        Reset  = 1'b1;
        Start  = 1'b0;
        Signed = 1'b0;
        DataA  = '0;
        DataB  = '0;
        repeat (2) @(posedge Clock);
        #1;
        check("reset_p", {16'd0, P}, 32'd0);
        check("reset_flags", {30'd0, Busy, Done}, 32'd0);
        @(negedge Clock);
        Reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge Clock);
            #1;
            check("idle_hold", {14'd0, Busy, Done, P}, 32'd0);
        end

        for (int i = 0; i < 11; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sgn,
                   vecs[i].p, vecs[i].lat, vecs[i].hold, vecs[i].disturb);
        end

        // Reset at E3 of 255x255 with Start still high: reset wins, P cleared.
        @(negedge Clock);
        Start  = 1'b1;
        Signed = 1'b0;
        DataA  = 8'd255;
        DataB  = 8'd255;
        repeat (3) @(posedge Clock);
        #1;
        check("midcalc_busy", {31'd0, Busy}, 32'd1);
        @(negedge Clock);
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        check("midrst_flags", {30'd0, Busy, Done}, 32'd0);
        check("midrst_p", {16'd0, P}, 32'd0);
        @(negedge Clock);
        Reset = 1'b0;
        Start = 1'b0;
        @(posedge Clock);
        #1;
        check("postrst_idle", {30'd0, Busy, Done}, 32'd0);
        run_op("after_rst_7x6", 8'd7, 8'd6, 1'b0, 16'h002A, 4, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_multiplier_param.md
# seq_multiplier_param

Parametrised sequential shift-and-add multiplier. It computes N×N → 2N products in either unsigned or two's-complement signed mode. It captures its own operands on a start handshake and terminates early once the remaining multiplier bits are zero. It is the next generation of the lab multiplier datapath/control pair and replaces the external operand-load strobes with a single Start/Done handshake.

## Interface
- N, default 8, operand width in bits (N ≥ 2); product width is 2N.
- Clock  input  1  sole clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request; sampled in IDLE to capture operands, held high by requester until Done seen.
- Signed  input  1  mode, sampled with operands: 1 = two's-complement, 0 = unsigned.
- DataA  input  N  multiplicand, sampled on acceptance edge only.
- DataB  input  N  multiplier, sampled on acceptance edge only.
- P  output  2N  registered product; holds last result until next result written.
- Done  output  1  high in DONE state.
- Busy  output  1  high in CALC state.

## Operation
- States: IDLE, CALC, DONE. Reset → IDLE.
- IDLE: Start=1 → acceptance edge:
  - Areg(2N) ← |DataA| zero-extended.
  - Breg(N) ← |DataB|.
  - Acc(2N) ← 0.
  - Neg ← Signed & (DataA[N-1] ^ DataB[N-1]).
  - Next state CALC.
  - Unsigned mode: |x| = x.
- CALC, each edge:
  - If Breg == 0: P ← Neg ? (−Acc mod 2^2N) : Acc; go DONE.
  - Else: if Breg[0], Acc ← Acc + Areg (mod 2^2N); Areg ← Areg << 1; Breg ← Breg >> 1; stay CALC.
- DONE: Start=1 → stay (Done held). Start=0 → IDLE.
- Start is ignored in CALC. A new operation requires Start to drop and be reasserted.
- Width rules:
  - Magnitude of −2^(N−1) is 2^(N−1), representable in N unsigned bits.
  - All products fit in 2N bits for both modes; no overflow flag.
  - Acc addition is 2N-bit, carry discarded.
- Zero operand: result 0, Neg irrelevant (−0 = 0).
- P is written only on the CALC→DONE edge; it is not cleared on acceptance.

## Timing
- Reset (any state, including mid-CALC): next edge state=IDLE, P=0, Done=0, Busy=0, Acc/Areg/Breg=0. Partial result is discarded.
- Reset has priority over Start.
- Let E0 = acceptance edge and b = bit length of |DataB| (0 for zero).
  - CALC spans edges E1..E(b+1).
  - Done and new P are valid after edge E(b+1).
  - Latency = b+1 cycles: minimum 1 (DataB=0), maximum N+1.
- Busy high after E0 through E(b+1) exclusive. Busy and Done are never high together.
- Done deasserts the cycle after Start is observed low in DONE.
- Earliest re-acceptance is the edge after returning to IDLE with Start=1.
- Operands may change freely after E0 without affecting the result.

## Test plan
- Reset then idle, N=8: P=0x0000, Done=0, Busy=0; hold Start=0 for 5 cycles → no state change.
- Unsigned 13×11: Done after E5, P=0x008F; hold Start 3 extra cycles → Done stays 1, P stable; drop Start → Done=0 next cycle.
- Unsigned 255×255: Done after E9, P=0xFE01. Unsigned 200×0: Done after E1, P=0x0000.
- Signed cases:
  - 5×(−3): Done after E3, P=0xFFF1.
  - (−1)×(−1): Done after E2, P=0x0001.
  - (−128)×(−128): Done after E9, P=0x4000.
  - (−128)×127: P=0xC080.
- Reset asserted at E3 during 255×255: IDLE, P=0, Busy=0 next cycle. Following 7×6 completes normally with P=0x002A.
- Operand change after E0 (DataA/DataB toggled each cycle during CALC) → result equals captured operands' product. Start toggled during CALC → no effect.
